// File: rtl/stage_5.sv
// Output byte FIFO: packs up to four carry-stage bytes per cycle and streams them one at a time.
// Overflowing groups are dropped whole; every anomaly latches a sticky error until reset.
module stage_5 #(
    parameter int S5_BITSTREAM_WIDTH = 8,
    parameter int S5_FIFO_DEPTH      = 16,
    parameter int S5_ADDR_WIDTH      = 4
) (
    input  logic                          s5_clk,
    input  logic                          s5_reset,
    input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_1,
    input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_2,
    input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_3,
    input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_last_bit,
    input  logic [2:0]                    in_carry_flag_bitstream,
    input  logic                          in_flag_last,
    input  logic                          in_carry_error,
    input  logic                          in_out_ready,
    output logic [S5_BITSTREAM_WIDTH-1:0] out_byte,
    output logic                          out_valid,
    output logic                          out_last,
    output logic                          out_accept,
    output logic [S5_ADDR_WIDTH:0]        out_count,
    output logic                          out_error
);

    localparam int CW = S5_ADDR_WIDTH + 1;
    localparam int RW = S5_ADDR_WIDTH + 2;

    logic [S5_BITSTREAM_WIDTH:0]   mem_q [S5_FIFO_DEPTH];
    logic [S5_ADDR_WIDTH-1:0]      wrPtr_q, wrPtr_d;
    logic [S5_ADDR_WIDTH-1:0]      rdPtr_q, rdPtr_d;
    logic [CW-1:0]                 count_q, count_d;
    logic                          error_q, error_d;

    logic [2:0]                    pushCount;
    logic [2:0]                    pushAccepted;
    logic                          flagBad;
    logic                          pop;
    logic [RW-1:0]                 room;
    logic                          fits;
    logic                          doPush;
    logic                          overflow;
    logic                          lastNoData;
    logic [S5_BITSTREAM_WIDTH-1:0] laneByte [4];
    logic [S5_ADDR_WIDTH-1:0]      laneAddr [4];
    logic                          laneLast [4];
    logic [S5_BITSTREAM_WIDTH:0]   headEntry;

    // The flag code is not a plain count: 2 means three bytes and 3 means two.
    always_comb begin
        pushCount = 3'd0;
        flagBad   = 1'b0;
        case (in_carry_flag_bitstream)
            3'd0:    pushCount = 3'd0;
            3'd1:    pushCount = 3'd1;
            3'd3:    pushCount = 3'd2;
            3'd2:    pushCount = 3'd3;
            3'd4:    pushCount = 3'd4;
            default: flagBad   = 1'b1;
        endcase
    end

    always_comb begin
        pop          = (count_q != '0) && in_out_ready;
        room         = RW'(S5_FIFO_DEPTH) - RW'(count_q) + RW'(pop);
        fits         = RW'(pushCount) <= room;
        doPush       = (pushCount != 3'd0) && fits;
        overflow     = (pushCount != 3'd0) && !fits;
        lastNoData   = in_flag_last && (in_carry_flag_bitstream == 3'd0);
        pushAccepted = doPush ? pushCount : 3'd0;

        count_d = count_q + CW'(pushAccepted) - CW'(pop);
        wrPtr_d = wrPtr_q + S5_ADDR_WIDTH'(pushAccepted);
        rdPtr_d = rdPtr_q + S5_ADDR_WIDTH'(pop);
        error_d = error_q | flagBad | overflow | lastNoData | in_carry_error;
    end

    // Only the final byte of an accepted group may carry the frame-end tag.
    always_comb begin
        laneByte[0] = in_carry_bit_1;
        laneByte[1] = in_carry_bit_2;
        laneByte[2] = in_carry_bit_3;
        laneByte[3] = in_carry_last_bit;
        for (int i = 0; i < 4; i++) begin
            laneAddr[i] = wrPtr_q + S5_ADDR_WIDTH'(i);
            laneLast[i] = in_flag_last && (3'(i) == (pushCount - 3'd1));
        end
    end

    always_ff @(posedge s5_clk) begin
        if (s5_reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            error_q <= 1'b0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    always_ff @(posedge s5_clk) begin
        if (!s5_reset && doPush) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < pushCount) begin
                    mem_q[laneAddr[i]] <= {laneLast[i], laneByte[i]};
                end
            end
        end
    end

    // Storage is never cleared, so head data is masked whenever the FIFO is empty.
    always_comb begin
        headEntry  = mem_q[rdPtr_q];
        out_valid  = (count_q != '0);
        out_byte   = out_valid ? headEntry[S5_BITSTREAM_WIDTH-1:0] : '0;
        out_last   = out_valid && headEntry[S5_BITSTREAM_WIDTH];
        out_accept = count_q <= CW'(S5_FIFO_DEPTH - 4);
        out_count  = count_q;
        out_error  = error_q;
    end

endmodule

// File: doc/stage_5.md
STAGE_5 -- requirements
Module: stage_5

Interface
REQ-001 SHALL have parameter S5_BITSTREAM_WIDTH, default 8, byte width.
REQ-002 SHALL have parameter S5_FIFO_DEPTH, default 16, byte-FIFO entries (power of two).
REQ-003 SHALL have parameter S5_ADDR_WIDTH, default 4, log2(S5_FIFO_DEPTH).
REQ-004 SHALL have port s5_clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port s5_reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have ports in_carry_bit_1, in_carry_bit_2, in_carry_bit_3, in_carry_last_bit, input, 8 each, bytes from the carry-propagation stage.
REQ-007 SHALL have port in_carry_flag_bitstream, input, 3, valid-byte code: 0 none; 1 bit_1; 3 bit_1,bit_2; 2 bit_1..bit_3; 4 bit_1..bit_3,last_bit.
REQ-008 SHALL have port in_flag_last, input, 1, marks the final byte group of the frame.
REQ-009 SHALL have port in_carry_error, input, 1, upstream error.
REQ-010 SHALL have port in_out_ready, input, 1, downstream ready.
REQ-011 SHALL have port out_byte, output, 8, FIFO head byte.
REQ-012 SHALL have port out_valid, output, 1, head byte valid.
REQ-013 SHALL have port out_last, output, 1, head byte is the frame's final byte.
REQ-014 SHALL have port out_accept, output, 1, high when occupancy <= S5_FIFO_DEPTH-4.
REQ-015 SHALL have port out_count, output, S5_ADDR_WIDTH+1, current occupancy.
REQ-016 SHALL have port out_error, output, 1, sticky error.

Function
REQ-017 Push count SHALL be 0/1/2/3/4 for flag codes 0/1/3/2/4; codes 5-7 SHALL push nothing and set out_error.
REQ-018 Pushed bytes SHALL be written in order bit_1, bit_2, bit_3, last_bit into consecutive entries.
REQ-019 A write at edge N SHALL make the data visible at the head (out_valid=1 if the FIFO was empty) in cycle N+1; latency is one cycle.
REQ-020 out_byte/out_last SHALL come from the head entry; out_valid = (count != 0).
REQ-021 Pop SHALL occur at an edge where out_valid && in_out_ready; one byte per cycle maximum.
REQ-022 Push and pop in the same cycle SHALL both occur; count_next = count + pushes - pop.
REQ-023 Push is accepted only if pushes <= S5_FIFO_DEPTH - count + pop; otherwise the whole group SHALL be dropped (no partial write), count SHALL change by -pop only, and out_error SHALL set.
REQ-024 Read/write pointers SHALL wrap modulo S5_FIFO_DEPTH; byte order SHALL be preserved across wrap.
REQ-025 in_flag_last=1 with an accepted nonzero flag SHALL tag only the last byte of that group with last=1; all other bytes are tagged 0.
REQ-026 in_flag_last=1 with flag 0 SHALL set out_error and tag nothing.
REQ-027 in_carry_error=1 in any cycle SHALL set out_error.
REQ-028 out_error SHALL remain set until reset; it SHALL NOT block push or pop.
REQ-029 out_accept SHALL be combinational from the registered count, with no dependence on same-cycle inputs.

Reset
REQ-030 s5_reset=1 at an edge SHALL clear pointers, count, and out_error; this takes priority over any simultaneous push or pop.
REQ-031 After reset, outputs SHALL be: out_valid=0, out_last=0, out_count=0, out_accept=1, out_error=0, out_byte=0.
REQ-032 Storage contents need not be cleared; out_byte SHALL be forced to 0 while out_valid=0.

Verification
REQ-033 Reset; flag=4 with bytes 0x11,0x22,0x33,0x44; ready=1 -> out_byte 0x11,0x22,0x33,0x44 on four consecutive cycles starting the next cycle; then out_valid=0.
REQ-034 ready=0; four flag=4 pushes -> out_count 4,8,12,16; out_accept=0 after the fourth; a fifth push with flag=1 -> out_error=1 and out_count stays 16.
REQ-035 count=5, ready=1, push flag=2 -> out_count=7 next cycle; head order unchanged.
REQ-036 20 consecutive flag=1 pushes of 0x00..0x13 with ready=1 -> output exactly 0x00..0x13 in order across pointer wrap.
REQ-037 flag=3 with bytes 0xAA,0xBB and in_flag_last=1 -> out_last=1 only while out_byte=0xBB.
REQ-038 count=9 with out_error=1, assert s5_reset together with a flag=4 push -> next cycle out_count=0, out_valid=0, out_error=0, out_accept=1.
